// File: rtl/fft_out_reorder.sv
// Reorders one bit-reversed FFT frame into natural order through a ping-pong register buffer.
// Latency: output beat 0 is registered one cycle after the last input beat of a frame is accepted.
// No backpressure: input is accepted every valid cycle, and each frame plays out in FRAME_CYC consecutive beats.
module fft_out_reorder #(
  parameter int DATA      = 16,
  parameter int ARRAY     = 16,
  parameter int FRAME_CYC = 32,
  parameter int LOG2N     = 9
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            valid_in,
  input  logic [ARRAY-1:0][DATA-1:0]      din_re,
  input  logic [ARRAY-1:0][DATA-1:0]      din_im,
  output logic                            valid_out,
  output logic                            frame_start,
  output logic                            frame_last,
  output logic [ARRAY-1:0][DATA-1:0]      dout_re,
  output logic [ARRAY-1:0][DATA-1:0]      dout_im
);

  localparam int LA = $clog2(ARRAY);
  localparam int LC = $clog2(FRAME_CYC);
  localparam int N  = ARRAY * FRAME_CYC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  localparam logic [LC-1:0] LAST_BEAT = LC'(FRAME_CYC - 1);

  // Reverse the LOG2N-bit sample index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [DATA-1:0] mem_re [2*N];
  logic [DATA-1:0] mem_im [2*N];

  logic [LC-1:0] wcnt_q, wcnt_d;
  logic          wb_q, wb_d;
  logic [0:0]    state_q, state_d;
  logic          rb_q, rb_d;
  logic [LC-1:0] rcnt_q, rcnt_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_last_q, frame_last_d;
  logic [ARRAY-1:0][DATA-1:0] dout_re_q, dout_re_d;
  logic [ARRAY-1:0][DATA-1:0] dout_im_q, dout_im_d;

  logic            frame_done;
  logic [LOG2N:0]  waddr [ARRAY];

  assign frame_done = valid_in && (wcnt_q == LAST_BEAT);

  // Scatter address of each lane: bin bitrev(beat*ARRAY+lane) in the current write bank.
  always_comb begin
    for (int l = 0; l < ARRAY; l++) begin
      waddr[l] = {wb_q, bitrev({wcnt_q, LA'(l)})};
    end
  end

  // Buffer write; contents need no reset since a bank is only read after a full frame lands in it.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int l = 0; l < ARRAY; l++) begin
        mem_re[waddr[l]] <= din_re[l];
        mem_im[waddr[l]] <= din_im[l];
      end
    end
  end

  // Next-state: write counter/bank flip, read FSM, registered natural-order output.
  always_comb begin
    wcnt_d        = wcnt_q;
    wb_d          = wb_q;
    state_d       = state_q;
    rb_d          = rb_q;
    rcnt_d        = rcnt_q;
    valid_out_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    dout_re_d     = dout_re_q;
    dout_im_d     = dout_im_q;

    if (valid_in) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    if (frame_done) begin
      wb_d = ~wb_q;
    end

    if (state_q == ST_READ) begin
      valid_out_d   = 1'b1;
      frame_start_d = (rcnt_q == '0);
      frame_last_d  = (rcnt_q == LAST_BEAT);
      for (int m = 0; m < ARRAY; m++) begin
        dout_re_d[m] = mem_re[{rb_q, rcnt_q, LA'(m)}];
        dout_im_d[m] = mem_im[{rb_q, rcnt_q, LA'(m)}];
      end
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == LAST_BEAT) begin
        state_d = ST_IDLE;
      end
    end

    // A completing frame always (re)starts the reader, giving gapless back-to-back output.
    if (frame_done) begin
      state_d = ST_READ;
      rb_d    = wb_q;
      rcnt_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q        <= '0;
      wb_q          <= 1'b0;
      state_q       <= ST_IDLE;
      rb_q          <= 1'b0;
      rcnt_q        <= '0;
      valid_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      dout_re_q     <= '0;
      dout_im_q     <= '0;
    end else begin
      wcnt_q        <= wcnt_d;
      wb_q          <= wb_d;
      state_q       <= state_d;
      rb_q          <= rb_d;
      rcnt_q        <= rcnt_d;
      valid_out_q   <= valid_out_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      dout_re_q     <= dout_re_d;
      dout_im_q     <= dout_im_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign dout_re     = dout_re_q;
  assign dout_im     = dout_im_q;

endmodule
